// File: rtl/clmul_issue_ctrl_if.sv
// Request/response bus between a caller and clmul_issue_ctrl.
// master = caller side, slave = controller side.
interface clmul_issue_ctrl_if #(
  parameter int TAG_W = 4
);
  logic             req_valid;
  logic             req_ready;
  logic             req_mul;
  logic [31:0]      req_rs1;
  logic [31:0]      req_rs2;
  logic [TAG_W-1:0] req_tag;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [63:0]      rsp_rd;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_err;

  modport master (
    output req_valid, req_mul, req_rs1, req_rs2, req_tag, rsp_ready,
    input  req_ready, rsp_valid, rsp_rd, rsp_tag, rsp_err
  );

  modport slave (
    input  req_valid, req_mul, req_rs1, req_rs2, req_tag, rsp_ready,
    output req_ready, rsp_valid, rsp_rd, rsp_tag, rsp_err
  );
endinterface

// File: rtl/clmul_issue_ctrl.sv
// Initiator for the start/busy/done carry-less multiply unit.
// Takes one request at a time, pulses cm_start once the unit is free,
// waits for cm_done (guarded by a watchdog) and returns the result.
module clmul_issue_ctrl #(
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 63
) (
  input  logic                clock,
  input  logic                reset,
  clmul_issue_ctrl_if.slave   bus,
  output logic                stray_done,
  output logic                cm_start,
  output logic                cm_mul,
  output logic [31:0]         cm_rs1,
  output logic [31:0]         cm_rs2,
  input  logic [63:0]         cm_rd,
  input  logic                cm_busy,
  input  logic                cm_done
);

  localparam int            TW        = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TIMEOUT_T = TW'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t           state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic             mul_q, mul_d;
  logic [31:0]      rs1_q, rs1_d;
  logic [31:0]      rs2_q, rs2_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [63:0]      rd_q, rd_d;
  logic             err_q, err_d;
  logic             stray_q, stray_d;

  logic             req_ready_c;
  logic             rsp_valid_c;
  logic             start_c;

  // Next-state, datapath latches and handshake outputs.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    mul_d       = mul_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    tag_d       = tag_q;
    rd_d        = rd_q;
    err_d       = err_q;
    stray_d     = stray_q;
    req_ready_c = 1'b0;
    rsp_valid_c = 1'b0;
    start_c     = 1'b0;

    case (state_q)
      S_IDLE: begin
        req_ready_c = 1'b1;
        if (bus.req_valid) begin
          mul_d   = bus.req_mul;
          rs1_d   = bus.req_rs1;
          rs2_d   = bus.req_rs2;
          tag_d   = bus.req_tag;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // Hold off while the unit is busy; the watchdog only covers WAIT.
        if (!cm_busy) begin
          start_c = 1'b1;
          timer_d = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // A done arriving in the expiry cycle still counts as a good result.
        if (cm_done) begin
          rd_d    = cm_rd;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else if (timer_q == TIMEOUT_T) begin
          rd_d    = '0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_RESP: begin
        rsp_valid_c = 1'b1;
        if (bus.rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A done we are not waiting for carries no data, only this sticky flag.
    if (cm_done && (state_q != S_WAIT)) begin
      stray_d = 1'b1;
    end

    // Keep the handshake quiet while reset is held.
    if (reset) begin
      req_ready_c = 1'b0;
      rsp_valid_c = 1'b0;
      start_c     = 1'b0;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      mul_q   <= 1'b0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      tag_q   <= '0;
      rd_q    <= '0;
      err_q   <= 1'b0;
      stray_q <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      mul_q   <= mul_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      tag_q   <= tag_d;
      rd_q    <= rd_d;
      err_q   <= err_d;
      stray_q <= stray_d;
    end
  end

  assign bus.req_ready = req_ready_c;
  assign bus.rsp_valid = rsp_valid_c;
  assign bus.rsp_rd    = rd_q;
  assign bus.rsp_tag   = tag_q;
  assign bus.rsp_err   = err_q;

  assign cm_start   = start_c;
  assign cm_mul     = mul_q;
  assign cm_rs1     = rs1_q;
  assign cm_rs2     = rs2_q;
  assign stray_done = stray_q;

endmodule

// File: tb/tb_clmul_issue_ctrl.sv
// Bench for clmul_issue_ctrl: behavioural clmul unit with programmable
// latency, a scoreboard queue of expected responses, directed cases and a
// random regression.
module tb_clmul_issue_ctrl;

  localparam int TAG_W   = 4;
  localparam int TIMEOUT = 63;

  typedef struct packed {
    logic [63:0]      rd;
    logic [TAG_W-1:0] tag;
    logic             err;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        stray_done, cm_start, cm_mul, cm_busy, cm_done;
  logic [31:0] cm_rs1, cm_rs2;
  logic [63:0] cm_rd;

  always #5 clock = ~clock;

  clmul_issue_ctrl_if #(.TAG_W(TAG_W)) bus ();

  clmul_issue_ctrl #(.TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
    .clock      (clock),
    .reset      (reset),
    .bus        (bus),
    .stray_done (stray_done),
    .cm_start   (cm_start),
    .cm_mul     (cm_mul),
    .cm_rs1     (cm_rs1),
    .cm_rs2     (cm_rs2),
    .cm_rd      (cm_rd),
    .cm_busy    (cm_busy),
    .cm_done    (cm_done)
  );

  // Reference result. mul=0 is plain carry-less multiply; the model unit
  // returns its complement for mul=1 so that cm_mul forwarding is visible.
  function automatic logic [63:0] unit_result(input logic mul, input logic [31:0] a,
                                              input logic [31:0] b);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (b[i]) r = r ^ ({32'b0, a} << i);
    end
    return mul ? ~r : r;
  endfunction

  // Model unit: busy from the cycle after start through the done cycle.
  int          lat = 1;
  logic        kill_done = 1'b0;
  logic        force_busy = 1'b0;
  logic        inject_done = 1'b0;
  int          rem = 0;
  logic        u_mul = 1'b0;
  logic [31:0] u_a = '0;
  logic [31:0] u_b = '0;

  always @(posedge clock) begin
    if (reset) begin
      rem <= 0;
    end else if (cm_start) begin
      rem   <= lat;
      u_mul <= cm_mul;
      u_a   <= cm_rs1;
      u_b   <= cm_rs2;
    end else if (rem != 0) begin
      rem <= rem - 1;
    end
  end

  assign cm_busy = (rem != 0) || force_busy;
  assign cm_done = ((rem == 1) && !kill_done) || inject_done;
  assign cm_rd   = (rem == 1) ? unit_result(u_mul, u_a, u_b) : 64'hDEADBEEF_CAFEF00D;

  // Cycle counter and start-pulse monitor.
  int cyc = 0;
  int start_cnt = 0;
  int start_cyc = 0;
  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (cm_start) begin
      start_cnt <= start_cnt + 1;
      start_cyc <= cyc;
    end
  end

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Drive one request until accepted; records the accept cycle.
  task automatic send(input logic mul, input logic [31:0] a, input logic [31:0] b,
                      input logic [TAG_W-1:0] tag, input logic err, output int acc);
    exp_t e;
    e.rd  = err ? 64'd0 : unit_result(mul, a, b);
    e.tag = tag;
    e.err = err;
    sb.push_back(e);
    bus.req_mul   = mul;
    bus.req_rs1   = a;
    bus.req_rs2   = b;
    bus.req_tag   = tag;
    bus.req_valid = 1'b1;
    acc = -1;
    for (int i = 0; i < 200; i++) begin
      if (bus.req_ready) begin
        acc = cyc;
        break;
      end
      tick();
    end
    if (acc < 0) check_eq("req_accept", {63'b0, bus.req_ready}, 64'd1);
    tick();
    bus.req_valid = 1'b0;
  endtask

  // Wait for a response, stall it, check hold, compare against scoreboard.
  task automatic wait_rsp(input int stall, output int rcyc);
    int               n;
    logic             stable;
    logic [63:0]      s_rd;
    logic [TAG_W-1:0] s_tag;
    logic             s_err;
    exp_t             e;
    n    = 0;
    rcyc = -1;
    while (!bus.rsp_valid && n < 500) begin
      tick();
      n++;
    end
    if (!bus.rsp_valid) begin
      check_eq("rsp_valid_wait", {63'b0, bus.rsp_valid}, 64'd1);
      if (sb.size() != 0) void'(sb.pop_front());
      return;
    end
    rcyc   = cyc;
    s_rd   = bus.rsp_rd;
    s_tag  = bus.rsp_tag;
    s_err  = bus.rsp_err;
    stable = 1'b1;
    for (int i = 0; i < stall; i++) begin
      tick();
      if (bus.rsp_rd !== s_rd || bus.rsp_tag !== s_tag || bus.rsp_err !== s_err ||
          bus.rsp_valid !== 1'b1 || bus.req_ready !== 1'b0) stable = 1'b0;
    end
    if (stall > 0) check_eq("rsp_hold", {63'b0, stable}, 64'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check_eq("rsp_rd", bus.rsp_rd, e.rd);
      check_eq("rsp_tag", {60'b0, bus.rsp_tag}, {60'b0, e.tag});
      check_eq("rsp_err", {63'b0, bus.rsp_err}, {63'b0, e.err});
    end
    $display("txn tag=%h rd=%h err=%0d cycle=%0d", bus.rsp_tag, bus.rsp_rd, bus.rsp_err, cyc);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    check_eq("rsp_valid_drop", {63'b0, bus.rsp_valid}, 64'd0);
  endtask

  int   acc, rcyc, s0;
  logic flag;

  initial begin
    bus.req_valid = 1'b0;
    bus.req_mul   = 1'b0;
    bus.req_rs1   = '0;
    bus.req_rs2   = '0;
    bus.req_tag   = '0;
    bus.rsp_ready = 1'b0;

    // Reset state
    repeat (3) tick();
    check_eq("rst_req_ready", {63'b0, bus.req_ready}, 64'd0);
    check_eq("rst_rsp_valid", {63'b0, bus.rsp_valid}, 64'd0);
    check_eq("rst_cm_start", {63'b0, cm_start}, 64'd0);
    check_eq("rst_stray", {63'b0, stray_done}, 64'd0);
    check_eq("rst_rsp_rd", bus.rsp_rd, 64'd0);
    check_eq("rst_rsp_tag", {60'b0, bus.rsp_tag}, 64'd0);
    check_eq("rst_cm_rs1", {32'b0, cm_rs1}, 64'd0);
    reset = 1'b0;
    tick();
    check_eq("idle_req_ready", {63'b0, bus.req_ready}, 64'd1);

    // 1: basic, L=4, 3 x 3 = 5 carry-less, single start pulse
    lat = 4;
    s0 = start_cnt;
    send(1'b0, 32'h3, 32'h3, 4'h5, 1'b0, acc);
    wait_rsp(0, rcyc);
    check_eq("t1_starts", 64'(start_cnt - s0), 64'd1);

    // 2: minimum latency, accept-to-rsp_valid is 3 cycles
    lat = 1;
    send(1'b0, 32'h8000_0000, 32'h2, 4'hA, 1'b0, acc);
    wait_rsp(0, rcyc);
    check_eq("t2_latency", 64'(rcyc - acc), 64'd3);

    // 3: unit busy for 6 cycles after accept, start withheld
    lat = 3;
    force_busy = 1'b1;
    s0 = start_cnt;
    send(1'b1, 32'h1234_5678, 32'h9ABC_DEF0, 4'h3, 1'b0, acc);
    flag = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (cm_start) flag = 1'b1;
      tick();
    end
    check_eq("t3_start_held", {63'b0, flag}, 64'd0);
    force_busy = 1'b0;
    wait_rsp(0, rcyc);
    check_eq("t3_starts", 64'(start_cnt - s0), 64'd1);

    // 4: done never comes; timer reaches TIMEOUT in cycle start+64,
    // so the error response is visible from cycle start+65
    kill_done = 1'b1;
    lat = 3;
    send(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'h7, 1'b1, acc);
    wait_rsp(0, rcyc);
    check_eq("t4_timeout_cycles", 64'(rcyc - start_cyc), 64'(TIMEOUT + 2));
    kill_done = 1'b0;
    repeat (4) tick();
    send(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'h8, 1'b0, acc);
    wait_rsp(0, rcyc);

    // 5: response stalled for 10 cycles
    lat = 2;
    send(1'b1, 32'h0F0F_0F0F, 32'h0000_0101, 4'hC, 1'b0, acc);
    wait_rsp(10, rcyc);

    // 6: reset while in WAIT drops the response
    lat = 8;
    send(1'b0, 32'hAAAA_5555, 32'h1357_9BDF, 4'hE, 1'b0, acc);
    repeat (3) tick();
    reset = 1'b1;
    tick();
    check_eq("t6_req_ready_rst", {63'b0, bus.req_ready}, 64'd0);
    tick();
    reset = 1'b0;
    void'(sb.pop_back());
    flag = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.rsp_valid) flag = 1'b1;
      tick();
    end
    check_eq("t6_no_rsp", {63'b0, flag}, 64'd0);
    check_eq("t6_rsp_rd", bus.rsp_rd, 64'd0);
    check_eq("t6_rsp_tag", {60'b0, bus.rsp_tag}, 64'd0);
    check_eq("t6_rsp_err", {63'b0, bus.rsp_err}, 64'd0);
    check_eq("t6_cm_rs2", {32'b0, cm_rs2}, 64'd0);
    check_eq("t6_req_ready", {63'b0, bus.req_ready}, 64'd1);
    lat = 2;
    send(1'b0, 32'h0000_00FF, 32'h0000_00FF, 4'h1, 1'b0, acc);
    wait_rsp(1, rcyc);
    check_eq("t6_stray_clear", {63'b0, stray_done}, 64'd0);
    inject_done = 1'b1;
    tick();
    inject_done = 1'b0;
    check_eq("t6_stray_set", {63'b0, stray_done}, 64'd1);

    // Random regression: random operands, latency and response stalls
    for (int k = 0; k < 200; k++) begin
      logic [31:0] a, b;
      logic        m;
      int          st;
      lat = int'($urandom_range(1, 10));
      st  = int'($urandom_range(0, 3));
      m   = 1'($urandom_range(0, 1));
      a   = $urandom;
      b   = $urandom;
      send(m, a, b, 4'(k), 1'b0, acc);
      wait_rsp(st, rcyc);
    end
    check_eq("sb_drained", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "bench did not finish");
  end

endmodule
